// File: rtl/mult_pio_if.sv
// PIO-side bundle for the shift-add multiplier: operand exports in, readback exports out.
interface mult_pio_if #(
  parameter int unsigned TIMER_W = 24
);
  logic [31:0]        a_in;
  logic [31:0]        b_in;
  logic [31:0]        product_out;
  logic [TIMER_W-1:0] timer_out;
  logic [31:0]        a_value_out;
  logic [31:0]        b_value_out;

  // HPS side: drives the operand PIOs, reads the result PIOs.
  modport master (
    output a_in,
    output b_in,
    input  product_out,
    input  timer_out,
    input  a_value_out,
    input  b_value_out
  );

  // Fabric engine side.
  modport slave (
    input  a_in,
    input  b_in,
    output product_out,
    output timer_out,
    output a_value_out,
    output b_value_out
  );
endinterface

// File: rtl/mult_pio_engine.sv
// Iterative unsigned shift-add multiplier fed by HPS operand PIOs.
// Retires one multiplier bit per RUN cycle and stops early once the
// remaining multiplier bits are all zero; timer_out reports RUN cycles.
module mult_pio_engine #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMER_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  mult_pio_if.slave  bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned PAD_W = 30 - WIDTH;
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      sh_mcand_q, sh_mcand_d;
  logic [WIDTH-1:0]   sh_mult_q, sh_mult_d;
  logic [31:0]        product_q, product_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_pulse_c;
  logic [PW-1:0]      addend_c;
  logic [PW-1:0]      acc_sum_c;
  logic               last_c;
  logic               unused_bits;

  // Operand bits outside the multiplicand/multiplier fields carry no meaning here.
  assign unused_bits = ^{bus.a_in[30:WIDTH], bus.b_in[31:WIDTH]};

  assign start_pulse_c = bus.a_in[31] & ~start_q;
  assign addend_c      = sh_mult_q[0] ? sh_mcand_q : '0;
  assign acc_sum_c     = acc_q + addend_c;
  assign last_c        = (sh_mult_q[WIDTH-1:1] == '0);

  // State and datapath registers; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      mcand_q    <= '0;
      mult_q     <= '0;
      acc_q      <= '0;
      sh_mcand_q <= '0;
      sh_mult_q  <= '0;
      product_q  <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.a_in[31];
      mcand_q    <= mcand_d;
      mult_q     <= mult_d;
      acc_q      <= acc_d;
      sh_mcand_q <= sh_mcand_d;
      sh_mult_q  <= sh_mult_d;
      product_q  <= product_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-datapath logic: accept on a start edge, then shift-add until empty.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mult_d     = mult_q;
    acc_d      = acc_q;
    sh_mcand_d = sh_mcand_q;
    sh_mult_d  = sh_mult_q;
    product_d  = product_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (start_pulse_c) begin
          mcand_d    = bus.a_in[WIDTH-1:0];
          mult_d     = bus.b_in[WIDTH-1:0];
          acc_d      = '0;
          sh_mcand_d = PW'(bus.a_in[WIDTH-1:0]);
          sh_mult_d  = bus.b_in[WIDTH-1:0];
          timer_d    = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Saturate rather than wrap so a short counter still reads "at least max".
        timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
        acc_d      = acc_sum_c;
        sh_mcand_d = sh_mcand_q << 1;
        sh_mult_d  = sh_mult_q >> 1;
        if (last_c) begin
          product_d = 32'(acc_sum_c);
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.product_out = product_q;
  assign bus.timer_out   = timer_q;
  assign bus.a_value_out = {busy_q, done_q, {PAD_W{1'b0}}, mcand_q};
  assign bus.b_value_out = 32'(mult_q);

endmodule

// File: tb/tb_mult_pio_engine.sv
// Bench for mult_pio_engine: an operation-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_mult_pio_engine;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMER_W = 24;
  localparam int unsigned SAT_TW  = 3;
  localparam int          TMAX    = (1 << TIMER_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  always #5 clk = ~clk;

  mult_pio_if #(.TIMER_W(TIMER_W)) mif ();
  mult_pio_if #(.TIMER_W(SAT_TW))  sif ();

  mult_pio_engine #(.WIDTH(WIDTH), .TIMER_W(TIMER_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  mult_pio_engine #(.WIDTH(WIDTH), .TIMER_W(SAT_TW)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RUN length from the multiplier alone: one cycle per bit up to its highest set bit.
  function automatic int run_cycles(input logic [15:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Operation-level model: an accepted start fixes the result a*b and a duration.
  bit          m_start_q = 1'b0;
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;
  logic [15:0] m_a       = '0;
  logic [15:0] m_b       = '0;
  logic [31:0] m_prod    = '0;
  int          m_timer   = 0;
  int          m_left    = 0;
  bit          m_pulse;

  always @(posedge clk) begin
    if (reset) begin
      m_start_q = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_a = '0; m_b = '0; m_prod = '0; m_timer = 0; m_left = 0;
    end else begin
      m_pulse   = mif.a_in[31] && !m_start_q;
      m_start_q = mif.a_in[31];
      if (!m_busy) begin
        if (m_pulse) begin
          m_a     = mif.a_in[15:0];
          m_b     = mif.b_in[15:0];
          m_busy  = 1'b1;
          m_done  = 1'b0;
          m_timer = 0;
          m_left  = run_cycles(m_b);
        end
      end else begin
        m_left--;
        if (m_timer < TMAX) m_timer++;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = 32'(m_a) * 32'(m_b);
        end
      end
    end
  end

  // Per-cycle comparison of every readback export against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("product", mif.product_out, m_prod);
      check("timer", 32'(mif.timer_out), 32'(m_timer));
      check("a_value", mif.a_value_out, {m_busy, m_done, 14'h0, m_a});
      check("b_value", mif.b_value_out, {16'h0, m_b});
    end
  end

  task automatic wait_done(output int busy_cnt);
    int n;
    busy_cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mif.a_value_out[31]) busy_cnt++;
    end while (!(mif.a_value_out[30] && !mif.a_value_out[31]) && n < 200);
    if (n >= 200) check("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int busy_cnt);
    @(negedge clk);
    mif.a_in = {16'h0, a};
    mif.b_in = {16'h0, b};
    @(negedge clk);
    mif.a_in[31] = 1'b1;
    wait_done(busy_cnt);
    mif.a_in[31] = 1'b0;
  endtask

  initial begin
    int bc;
    int n;
    logic [15:0] ra, rb;

    mif.a_in = '0; mif.b_in = '0;
    sif.a_in = '0; sif.b_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_product", mif.product_out, 32'h0);
    check("rst_a_value", mif.a_value_out, 32'h0);
    check("rst_timer", 32'(mif.timer_out), 32'h0);
    reset = 1'b0;

    // Basic multiply
    run_op(16'h0003, 16'h0005, bc);
    check("basic_product", mif.product_out, 32'd15);
    check("basic_timer", 32'(mif.timer_out), 32'd3);
    check("basic_a_value", mif.a_value_out, 32'h4000_0003);
    check("basic_b_value", mif.b_value_out, 32'd5);
    check("basic_busy_cycles", 32'(bc), 32'd3);

    // Maximum operands
    run_op(16'hFFFF, 16'hFFFF, bc);
    check("max_product", mif.product_out, 32'hFFFE_0001);
    check("max_timer", 32'(mif.timer_out), 32'd16);
    check("max_busy_cycles", 32'(bc), 32'd16);

    // Zero multiplier / zero multiplicand with top multiplier bit
    run_op(16'h1234, 16'h0000, bc);
    check("zero_b_product", mif.product_out, 32'h0);
    check("zero_b_timer", 32'(mif.timer_out), 32'd1);
    run_op(16'h0000, 16'h8000, bc);
    check("zero_a_product", mif.product_out, 32'h0);
    check("zero_a_timer", 32'(mif.timer_out), 32'd16);

    // Start retoggled and operands changed mid-RUN; level held through completion
    @(negedge clk);
    mif.a_in = 32'h0000_0007;
    mif.b_in = 32'h0000_00F0;
    @(negedge clk);
    mif.a_in[31] = 1'b1;
    repeat (3) @(negedge clk);
    mif.a_in[31] = 1'b0;
    mif.a_in[15:0] = 16'h1111;
    mif.b_in = 32'h0000_FFFF;
    @(negedge clk);
    mif.a_in[31] = 1'b1;
    wait_done(bc);
    check("hold_product", mif.product_out, 32'h0000_0690);
    check("hold_b_value", mif.b_value_out, 32'h0000_00F0);
    check("hold_timer", 32'(mif.timer_out), 32'd8);
    repeat (6) begin
      @(negedge clk);
      check("hold_no_restart", 32'(mif.a_value_out[31]), 32'd0);
    end
    mif.a_in[31] = 1'b0;

    // Timer saturation on the narrow-counter instance
    @(negedge clk);
    sif.a_in = 32'h0000_0001;
    sif.b_in = 32'h0000_FFFF;
    @(negedge clk);
    sif.a_in[31] = 1'b1;
    bc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (sif.a_value_out[31]) bc++;
    end while (!(sif.a_value_out[30] && !sif.a_value_out[31]) && n < 200);
    sif.a_in[31] = 1'b0;
    check("sat_timer", 32'(sif.timer_out), 32'd7);
    check("sat_product", sif.product_out, 32'h0000_FFFF);
    check("sat_busy_cycles", 32'(bc), 32'd16);

    // Reset in the middle of an operation
    @(negedge clk);
    mif.a_in = 32'h0000_FFFF;
    mif.b_in = 32'h0000_FFFF;
    @(negedge clk);
    mif.a_in[31] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    mif.a_in[31] = 1'b0;
    @(negedge clk);
    check("midrst_product", mif.product_out, 32'h0);
    check("midrst_a_value", mif.a_value_out, 32'h0);
    check("midrst_b_value", mif.b_value_out, 32'h0);
    check("midrst_timer", 32'(mif.timer_out), 32'h0);
    reset = 1'b0;
    run_op(16'h00FF, 16'h0101, bc);
    check("postrst_product", mif.product_out, 32'h0000_FFFF);
    check("postrst_timer", 32'(mif.timer_out), 32'd9);

    // Randomised operations, occasionally disturbing inputs mid-RUN
    for (int k = 0; k < 120; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom >> $urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mif.a_in = {16'h0, ra};
        mif.b_in = {16'h0, rb};
        @(negedge clk);
        mif.a_in[31] = 1'b1;
        @(negedge clk);
        mif.a_in[15:0] = 16'($urandom);
        mif.b_in = $urandom;
        if (!(mif.a_value_out[30] && !mif.a_value_out[31])) wait_done(bc);
        mif.a_in[31] = 1'b0;
      end else begin
        run_op(ra, rb, bc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
